// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
//   It runs WIDTH iterations of shift-add multiply or restoring divide on the
//   operand magnitudes, then applies sign correction in a FINISH cycle.
// Ports
//   Clk, Rst            clock, synchronous active-low reset
//   Start, Op, A, B     issue request (sampled in IDLE only)
//   HiLoRead            decode stage holds MFHI/MFLO
//   HiWrite, LoWrite    MTHI/MTLO strobes, WrData is their data
//   Busy, Done          in flight / one-cycle completion pulse
//   DivByZero           qualifies Done for a divide with B == 0
//   Stall               holds the pipeline while Busy and HI/LO or unit is needed
//   HI, LO              architectural result registers
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiLoRead,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic             Stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t               state, nstate;
  logic [CW-1:0]        cnt;
  logic [1:0]           op_q;
  logic                 sa, sb, dbz;
  logic [WIDTH-1:0]     opnd;   // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [2*WIDTH-1:0]   acc;    // mul: {partial, multiplier}; div: {remainder, dividend/quotient}

  // Operand magnitudes at issue; 0x80000000 negates to itself, read as unsigned.
  logic             in_signed, in_div, in_dbz;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign in_signed = ~Op[0];
  assign in_div    = Op[1];
  assign in_dbz    = in_div && (B == '0);
  assign abs_a     = (in_signed && A[WIDTH-1]) ? -A : A;
  assign abs_b     = (in_signed && B[WIDTH-1]) ? -B : B;

  // One shift-add step: add multiplicand to upper half if multiplier LSB set,
  // then shift the whole accumulator right.
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_next;
  assign msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {msum, acc[WIDTH-1:1]};

  // One restoring-divide step: shift in the next dividend bit, try subtract.
  logic [WIDTH:0]     dshift, dtrial;
  logic [2*WIDTH-1:0] div_next;
  assign dshift   = acc[2*WIDTH-1:WIDTH-1];
  assign dtrial   = dshift - {1'b0, opnd};
  assign div_next = dtrial[WIDTH] ? {dshift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {dtrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign correction applied in FINISH.
  logic               sgn, neg;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign sgn      = ~op_q[0];
  assign neg      = sa ^ sb;
  assign prod_fix = (sgn && neg) ? -acc : acc;
  assign quo_fix  = (sgn && neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = (sgn && sa)  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign Busy  = (state != IDLE);
  assign Stall = Busy & (Start | HiLoRead | HiWrite | LoWrite);

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (Start) nstate = in_dbz ? FINISH : RUN;
      RUN:     if (cnt == CW'(WIDTH-1)) nstate = FINISH;
      FINISH:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      dbz       <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else begin
      state     <= nstate;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            op_q <= Op;
            sa   <= in_signed & A[WIDTH-1];
            sb   <= in_signed & B[WIDTH-1];
            dbz  <= in_dbz;
            cnt  <= '0;
            opnd <= in_div ? abs_b : abs_a;
            acc  <= {{WIDTH{1'b0}}, (in_div ? abs_a : abs_b)};
          end
          // MTHI/MTLO only land here; while busy the pipeline is stalled instead.
          if (HiWrite) HI <= WrData;
          if (LoWrite) LO <= WrData;
        end
        RUN: begin
          acc <= op_q[1] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        FINISH: begin
          Done      <= 1'b1;
          DivByZero <= dbz;
          if (!dbz) begin
            if (op_q[1]) begin
              HI <= rem_fix;
              LO <= quo_fix;
            end else begin
              HI <= prod_fix[2*WIDTH-1:WIDTH];
              LO <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst, Start, HiLoRead, HiWrite, LoWrite;
  logic [1:0]   Op;
  logic [W-1:0] A, B, WrData;
  logic         Busy, Done, DivByZero, Stall;
  logic [W-1:0] HI, LO;

  int passed = 0;
  int total  = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiLoRead(HiLoRead), .HiWrite(HiWrite), .LoWrite(LoWrite), .WrData(WrData),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Stall(Stall),
    .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue an op and wait (bounded) for Done; lat is the cycle Done appeared in.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    Op = op; A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    lat = 1;
    while (!Done && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bad, dones;
    Rst = 1'b0; Start = 0; HiLoRead = 0; HiWrite = 0; LoWrite = 0;
    Op = 0; A = 0; B = 0; WrData = 0;
    tick(); tick();
    Rst = 1'b1;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_dbz", DivByZero, 0);
    chk("rst_hilo", {HI, LO}, 64'h0);

    // MULTU 0xFFFFFFFF^2 with hazards injected while busy.
    Op = 2'b01; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; Start = 1'b1;
    bad = 0;
    for (int c = 1; c <= 33; c++) begin
      tick();
      Start = 0; HiLoRead = 0; LoWrite = 0;
      if (Busy !== 1'b1 || Done !== 1'b0) bad++;
      if (c == 5) begin
        HiLoRead = 1'b1; #1;
        chk("stall_hiloread", Stall, 1);
      end
      if (c == 10) begin
        Start = 1'b1; Op = 2'b10; A = 32'd9; B = 32'd3; #1;
        chk("stall_start", Stall, 1);
      end
      if (c == 12) begin
        LoWrite = 1'b1; WrData = 32'hDEAD_BEEF; #1;
        chk("stall_lowrite", Stall, 1);
      end
    end
    Start = 0; HiLoRead = 0; LoWrite = 0;
    chk("multu_busy_1_33", bad, 0);
    tick();  // cycle 34
    chk("multu_done", Done, 1);
    chk("multu_busy_done", Busy, 0);
    chk("multu_dbz", DivByZero, 0);
    chk("multu_hilo", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    HiLoRead = 1'b1; #1;
    chk("done_read_nostall", Stall, 0);
    HiLoRead = 1'b0;
    tick();
    chk("done_one_pulse", Done, 0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat);
    chk("mult_lat", lat, 34);
    chk("mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
    chk("div_neg7_2", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("div_min_m1", {HI, LO}, 64'h0000_0000_8000_0000);

    // MTHI+MTLO together, then MTHI alone.
    HiWrite = 1; LoWrite = 1; WrData = 32'hA5A5_A5A5;
    tick();
    HiWrite = 0; LoWrite = 0;
    chk("mt_both", {HI, LO}, 64'hA5A5_A5A5_A5A5_A5A5);
    HiWrite = 1; WrData = 32'h1234_5678;
    tick();
    HiWrite = 0;
    chk("mthi", {HI, LO}, 64'h1234_5678_A5A5_A5A5);

    // DIVU by zero, then back-to-back DIVU issued in its Done cycle.
    Op = 2'b11; A = 32'd100; B = 32'd0; Start = 1'b1;
    tick();
    Start = 0;
    chk("dbz_busy_c1", Busy, 1);
    chk("dbz_nodone_c1", Done, 0);
    tick();
    chk("dbz_done_c2", Done, 1);
    chk("dbz_flag", DivByZero, 1);
    chk("dbz_hilo_kept", {HI, LO}, 64'h1234_5678_A5A5_A5A5);
    run_op(2'b11, 32'd100, 32'd7, lat);
    chk("divu_b2b_lat", lat, 34);
    chk("divu_b2b", {HI, LO}, {32'd2, 32'd14});
    chk("divu_b2b_dbz", DivByZero, 0);

    // Reset during a MULT: in-flight result is dropped.
    Op = 2'b00; A = 32'd5; B = 32'd6; Start = 1'b1;
    tick();
    Start = 0;
    for (int c = 2; c <= 11; c++) tick();
    Rst = 1'b0;
    tick();  // cycle 12
    chk("midrst_busy", Busy, 0);
    chk("midrst_hilo", {HI, LO}, 64'h0);
    Rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (Done) dones++;
    end
    chk("midrst_no_done", dones, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle integer multiply/divide unit with its own sequencing FSM and architectural HI/LO registers. It sits beside the single-cycle ALU and is issued by the main Controller for MULT, MULTU, DIV and DIVU. It runs a 32-iteration shift-add multiply or restoring divide. It raises a stall toward the pipeline while a dependent instruction would observe stale HI/LO or issue a second operation.

## Interface
- WIDTH, 32: operand width; the iteration count equals WIDTH.
- Clk  in  1  sole clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-low reset.
- Start  in  1  issue request; sampled only in IDLE.
- Op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- A  in  WIDTH  multiplicand or dividend; captured on accepted Start.
- B  in  WIDTH  multiplier or divisor; captured on accepted Start.
- HiLoRead  in  1  the decode stage holds an MFHI/MFLO.
- HiWrite  in  1  MTHI strobe.
- LoWrite  in  1  MTLO strobe.
- WrData  in  WIDTH  data for MTHI/MTLO.
- Busy  out  1  operation in flight (RUN or FINISH).
- Done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- DivByZero  out  1  valid with Done; set when a DIV or DIVU had B == 0.
- Stall  out  1  combinational: Busy & (Start | HiLoRead | HiWrite | LoWrite).
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

## Operation
- FSM states:
  - IDLE: if Start, latch Op, |A| and |B| (absolute values only for signed ops) and the sign bits, clear the counter, go to RUN. A DIV or DIVU with B == 0 goes straight to FINISH.
  - RUN: one iteration per cycle; counter counts 0..WIDTH-1; at WIDTH-1 go to FINISH.
  - FINISH: apply sign correction, write HI/LO, go to IDLE.
- Multiply: 2*WIDTH-bit accumulator using unsigned shift-add on the magnitudes.
  - Signed op: negate the 64-bit product when sign(A) != sign(B).
  - HI = product[63:32], LO = product[31:0].
- Divide: restoring division on the magnitudes.
  - LO = quotient, HI = remainder.
  - Signed op: negate the quotient when sign(A) != sign(B); the remainder takes the sign of the dividend.
  - The magnitude of 0x80000000 is treated as unsigned 0x80000000, so no overflow path exists. 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
- Divide by zero: no iteration. HI/LO are left unchanged, and DivByZero = 1 with Done.
- MTHI/MTLO: write HI/LO from WrData only in IDLE. Strobes while Busy are dropped; the pipeline is stalled through Stall and reissues them. MTHI and MTLO in the same cycle write both registers.
- Start while Busy is ignored; Stall holds the issuing instruction.
- Start in the Done cycle is accepted, since the FSM is in IDLE. This allows back-to-back operations.

## Timing
- Reset (Rst = 0 at an edge): state IDLE, counter 0, Busy 0, Done 0, DivByZero 0, HI 0, LO 0.
  - Applies mid-operation too: the in-flight result is discarded and no Done is produced.
- Start is sampled high at the end of cycle 0.
  - Busy = 1 in cycles 1..WIDTH+1: RUN in cycles 1..32, FINISH in cycle 33.
  - Done = 1 in cycle 34 only, with Busy = 0 and the HI/LO results visible.
  - Start-to-Done latency is WIDTH+2 = 34 cycles.
- Divide by zero:
  - Busy = 1 in cycle 1 (FINISH).
  - Done = 1 and DivByZero = 1 in cycle 2.
- DivByZero is 0 for every other Done and 0 outside Done cycles.
- HiLoRead in the Done cycle does not stall and returns the new result.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Done in cycle 34 with HI=0xFFFFFFFE, LO=0x00000001; Busy high in cycles 1..33.
- MULT A=-3 (0xFFFFFFFD), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Signed divides:
  - DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
- MTHI 0x12345678, then DIVU A=100, B=0 -> Done and DivByZero in cycle 2, HI=0x12345678, LO unchanged. Then DIVU A=100, B=7 issued in that Done cycle -> Done 34 cycles later with LO=14, HI=2.
- During a MULTU:
  - HiLoRead=1 in cycle 5 -> Stall=1.
  - Start with Op=DIV in cycle 10 -> ignored; the MULTU result is unaffected.
  - LoWrite in cycle 12 -> dropped.
- Rst=0 in cycle 11 of a MULT -> cycle 12 shows Busy=0, HI=LO=0, and no Done pulse afterwards.
